// File: rtl/pc_branch_unit.sv
// Program counter and fetch sequencer with a writable branch-offset table.
// Each RUN cycle the PC advances by 1, or by tbl[how_high] when a branch is taken.
module pc_branch_unit #(
   parameter int D     = 12,
   parameter int N_IDX = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic             stall,
   input  logic             branch_en,
   input  logic [N_IDX-1:0] how_high,
   input  logic             halt_req,
   input  logic             tbl_we,
   input  logic [N_IDX-1:0] tbl_waddr,
   input  logic [D-1:0]     tbl_wdata,
   output logic [D-1:0]     pc,
   output logic             running,
   output logic             done,
   output logic             branch_taken,
   output logic [D-1:0]     cur_target
);

   localparam int TBL_DEPTH = 2 ** N_IDX;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t         state, state_next;
   logic [D-1:0]   pc_next;
   logic           branch_next;
   logic [D-1:0]   tbl [TBL_DEPTH];

   // Boot-time loop offsets; entries beyond the first eight default to zero.
   function automatic logic [D-1:0] default_offset(input int idx);
      case (idx)
         0:       return D'(2);
         1:       return D'(8);
         2:       return D'(22);
         3:       return D'(-30);
         4:       return D'(314);
         5:       return D'(-316);
         6:       return D'(346);
         7:       return D'(-352);
         default: return '0;
      endcase
   endfunction

   assign cur_target = tbl[how_high];
   assign running    = (state == RUN);
   assign done       = (state == HALT);

   always_comb begin
      state_next  = state;
      pc_next     = pc;
      branch_next = 1'b0;
      case (state)
         IDLE: begin
            pc_next = '0;
            if (start) state_next = RUN;
         end
         RUN: begin
            if (halt_req) begin
               state_next = HALT;
            end else if (stall) begin
               pc_next = pc;
            end else if (branch_en) begin
               pc_next     = pc + tbl[how_high];
               branch_next = 1'b1;
            end else begin
               pc_next = pc + D'(1);
            end
         end
         HALT: begin
            if (start) begin
               state_next = RUN;
               pc_next    = '0;
            end
         end
         default: begin
            state_next = IDLE;
            pc_next    = '0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         pc           <= '0;
         branch_taken <= 1'b0;
      end else begin
         // NOTE: non-blocking updates keep every register sampling pre-edge values,
         // which is also why a same-cycle branch sees the old table entry.
         state        <= state_next;
         pc           <= pc_next;
         branch_taken <= branch_next;
      end
   end

   // NOTE: the table is deliberately reset, because reset must restore the boot
   // offsets and override any write presented in the same cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < TBL_DEPTH; i++) tbl[i] <= default_offset(i);
      end else if (tbl_we) begin
         tbl[tbl_waddr] <= tbl_wdata;
      end
   end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: expected per-cycle outputs go into a
// scoreboard queue as stimulus is driven and are popped after each clock edge.
module tb_pc_branch_unit;

   localparam int D     = 12;
   localparam int N_IDX = 3;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             start;
   logic             stall;
   logic             branch_en;
   logic [N_IDX-1:0] how_high;
   logic             halt_req;
   logic             tbl_we;
   logic [N_IDX-1:0] tbl_waddr;
   logic [D-1:0]     tbl_wdata;
   logic [D-1:0]     pc;
   logic             running;
   logic             done;
   logic             branch_taken;
   logic [D-1:0]     cur_target;

   typedef struct {
      logic [D-1:0] pc;
      logic         running;
      logic         done;
      logic         branch_taken;
      string        tag;
   } exp_t;

   exp_t sb [$];
   int   total = 0;
   int   bad   = 0;

   pc_branch_unit #(.D(D), .N_IDX(N_IDX)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .start        (start),
      .stall        (stall),
      .branch_en    (branch_en),
      .how_high     (how_high),
      .halt_req     (halt_req),
      .tbl_we       (tbl_we),
      .tbl_waddr    (tbl_waddr),
      .tbl_wdata    (tbl_wdata),
      .pc           (pc),
      .running      (running),
      .done         (done),
      .branch_taken (branch_taken),
      .cur_target   (cur_target)
   );

   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
      end
   endtask

   task automatic quiet();
      Reset = 1'b0; start = 1'b0; stall = 1'b0; branch_en = 1'b0;
      how_high = '0; halt_req = 1'b0; tbl_we = 1'b0; tbl_waddr = '0; tbl_wdata = '0;
   endtask

   // Push the expectation for the edge about to happen, clock, then pop and compare.
   task automatic cycle(input logic [D-1:0] e_pc, input logic e_run, input logic e_done,
                        input logic e_bt, input string tag);
      exp_t e;
      e.pc = e_pc; e.running = e_run; e.done = e_done; e.branch_taken = e_bt; e.tag = tag;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      check_val({e.tag, ".pc"}, pc, e.pc);
      check_val({e.tag, ".running"}, D'(running), D'(e.running));
      check_val({e.tag, ".done"}, D'(done), D'(e.done));
      check_val({e.tag, ".branch_taken"}, D'(branch_taken), D'(e.branch_taken));
   endtask

   task automatic target(input logic [N_IDX-1:0] idx, input logic [D-1:0] exp, input string tag);
      how_high = idx;
      #1;
      check_val(tag, cur_target, exp);
   endtask

   initial begin
      logic [D-1:0] defaults [8];
      defaults = '{12'h002, 12'h008, 12'h016, 12'hFE2, 12'h13A, 12'hEC4, 12'h15A, 12'hEA0};

      quiet();
      Reset = 1'b1;
      cycle(12'h000, 1'b0, 1'b0, 1'b0, "reset");
      for (int i = 0; i < 8; i++) target(N_IDX'(i), defaults[i], $sformatf("default_tbl%0d", i));

      quiet();
      cycle(12'h000, 1'b0, 1'b0, 1'b0, "idle_hold");

      // start held high throughout RUN must be ignored
      start = 1'b1;
      for (int i = 0; i < 5; i++) cycle(D'(i), 1'b1, 1'b0, 1'b0, $sformatf("run_adv%0d", i));
      start = 1'b0;
      for (int i = 5; i <= 10; i++) cycle(D'(i), 1'b1, 1'b0, 1'b0, $sformatf("run_adv%0d", i));

      branch_en = 1'b1; how_high = 3'd2;
      cycle(12'd32, 1'b1, 1'b0, 1'b1, "branch_idx2");
      how_high = 3'd3;
      cycle(12'd2, 1'b1, 1'b0, 1'b1, "branch_idx3_neg");
      branch_en = 1'b0;
      cycle(12'd3, 1'b1, 1'b0, 1'b0, "branch_pulse_end");

      tbl_we = 1'b1; tbl_waddr = 3'd0; tbl_wdata = 12'hFFB;
      cycle(12'd4, 1'b1, 1'b0, 1'b0, "write_tbl0");
      tbl_we = 1'b0;
      target(3'd0, 12'hFFB, "tbl0_new");
      branch_en = 1'b1; how_high = 3'd0;
      cycle(12'hFFF, 1'b1, 1'b0, 1'b1, "wrap_down");
      branch_en = 1'b0;
      cycle(12'h000, 1'b1, 1'b0, 1'b0, "wrap_up");

      tbl_we = 1'b1; tbl_waddr = 3'd1; tbl_wdata = 12'd100;
      branch_en = 1'b1; how_high = 3'd1;
      cycle(12'd8, 1'b1, 1'b0, 1'b1, "collision_old_value");
      tbl_we = 1'b0;
      target(3'd1, 12'd100, "tbl1_new");
      cycle(12'd108, 1'b1, 1'b0, 1'b1, "branch_new_value");

      stall = 1'b1;
      cycle(12'd108, 1'b1, 1'b0, 1'b0, "stall_beats_branch");
      stall = 1'b0; branch_en = 1'b0;
      tbl_we = 1'b1; tbl_waddr = 3'd7; tbl_wdata = 12'hFA7;
      cycle(12'd109, 1'b1, 1'b0, 1'b0, "write_tbl7");
      tbl_we = 1'b0; branch_en = 1'b1; how_high = 3'd7;
      cycle(12'd20, 1'b1, 1'b0, 1'b1, "branch_to_20");

      halt_req = 1'b1; stall = 1'b1; branch_en = 1'b1;
      cycle(12'd20, 1'b0, 1'b1, 1'b0, "halt_priority");
      stall = 1'b0; branch_en = 1'b0;
      cycle(12'd20, 1'b0, 1'b1, 1'b0, "halt_hold");
      halt_req = 1'b0; start = 1'b1;
      cycle(12'd0, 1'b1, 1'b0, 1'b0, "restart");
      start = 1'b0;

      tbl_we = 1'b1; tbl_waddr = 3'd5; tbl_wdata = 12'd7;
      cycle(12'd1, 1'b1, 1'b0, 1'b0, "write_tbl5");
      tbl_waddr = 3'd4; tbl_wdata = 12'd48;
      cycle(12'd2, 1'b1, 1'b0, 1'b0, "write_tbl4");
      tbl_we = 1'b0;
      target(3'd5, 12'd7, "tbl5_new");
      branch_en = 1'b1; how_high = 3'd4;
      cycle(12'd50, 1'b1, 1'b0, 1'b1, "branch_to_50");

      // reset must beat the in-flight write and the branch
      Reset = 1'b1; tbl_we = 1'b1; tbl_waddr = 3'd5; tbl_wdata = 12'h123;
      cycle(12'd0, 1'b0, 1'b0, 1'b0, "reset_midrun");
      quiet();
      target(3'd5, 12'hEC4, "tbl5_restored");
      branch_en = 1'b1; how_high = 3'd2;
      cycle(12'd0, 1'b0, 1'b0, 1'b0, "idle_after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
